// File: rtl/mul_unit_pipelined_if.sv
// Issue/writeback bundle of the pipelined multiply unit.
// The unit plugs into the slave modport; issue logic and the writeback arbiter use master.
interface mul_unit_pipelined_if #(
  parameter int XLEN = 32,
  parameter int ID_W = 3
);
  logic            issue_new_request;
  logic            issue_ready;
  logic [ID_W-1:0] issue_id;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            wb_done;
  logic            wb_ack;
  logic [ID_W-1:0] wb_id;
  logic [XLEN-1:0] wb_rd;

  modport master (
    output issue_new_request, issue_id, op, rs1, rs2, wb_ack,
    input  issue_ready, wb_done, wb_id, wb_rd
  );

  modport slave (
    input  issue_new_request, issue_id, op, rs1, rs2, wb_ack,
    output issue_ready, wb_done, wb_id, wb_rd
  );
endinterface

// File: rtl/mul_unit_pipelined.sv
// Stall-able RISC-V MUL/MULH/MULHSU/MULHU pipeline, STAGES cycles issue-to-done.
// Optional product reuse (identical operands, empty pipe) under `MUL_PRODUCT_REUSE_EN.
module mul_unit_pipelined #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int ID_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mul_unit_pipelined_if.slave  bus
);
  localparam int EW = XLEN + 1;
  localparam int PW = 2 * XLEN;
  localparam int L  = STAGES - 1;

  logic [L:0]                r_vld;
  logic [L:0]                w_adv;
  logic [L:0]                r_mulh;
  logic [L:0][ID_W-1:0]      r_id;
  logic signed [EW-1:0]      r_a;
  logic signed [EW-1:0]      r_b;
  logic [L:1][PW-1:0]        r_prod;

  logic [L:1][PW-1:0]        w_sp;
  logic [L:1]                w_sv;
  logic [L:1]                w_sm;
  logic [L:1][ID_W-1:0]      w_si;

  logic [PW-1:0]             w_lp;
  logic                      w_lv;
  logic                      w_lm;
  logic [ID_W-1:0]           w_li;

  logic                      w_s1;
  logic                      w_s2;
  logic [EW-1:0]             w_a_ext;
  logic [EW-1:0]             w_b_ext;
  logic                      w_acc;
  logic                      w_hit;
  logic [PW-1:0]             w_prod;

  // Unrolled form of adv[k] = ~valid[k] | adv[k+1]: a stage moves unless
  // it and everything downstream is full and writeback is holding.
  for (genvar k = 0; k <= L; k++) begin : g_adv
    assign w_adv[k] = ~(&r_vld[L:k]) | bus.wb_ack;
  end

  assign w_s1    = bus.op[0] ^ bus.op[1];
  assign w_s2    = ~bus.op[1];
  assign w_a_ext = {w_s1 & bus.rs1[XLEN-1], bus.rs1};
  assign w_b_ext = {w_s2 & bus.rs2[XLEN-1], bus.rs2};
  assign w_acc   = bus.issue_new_request & w_adv[0];

  // Sign-extending to 2*XLEN before multiplying yields the low 2*XLEN bits of the signed product.
  assign w_prod = PW'(r_a) * PW'(r_b);

  for (genvar k = 1; k <= L; k++) begin : g_src
    if (k == 1) begin : g_s1
      assign w_sp[k] = w_prod;
      assign w_sv[k] = r_vld[0];
      assign w_sm[k] = r_mulh[0];
      assign w_si[k] = r_id[0];
    end else begin : g_sn
      assign w_sp[k] = r_prod[k-1];
      assign w_sv[k] = r_vld[k-1];
      assign w_sm[k] = r_mulh[k-1];
      assign w_si[k] = r_id[k-1];
    end
  end

`ifdef MUL_PRODUCT_REUSE_EN
  logic                r_tag_v;
  logic [EW-1:0]       r_tag_a;
  logic [EW-1:0]       r_tag_b;
  logic [PW-1:0]       r_tag_prod;
  logic                w_hit_acc;

  assign w_hit     = r_tag_v & (w_a_ext == r_tag_a) & (w_b_ext == r_tag_b) & ~(|r_vld);
  assign w_hit_acc = w_acc & w_hit;

  // A hit skips straight into the last stage; only possible with the pipe empty.
  assign w_lv = w_sv[L] | w_hit_acc;
  assign w_lp = w_hit_acc ? r_tag_prod : w_sp[L];
  assign w_lm = w_hit_acc ? (bus.op != 2'b00) : w_sm[L];
  assign w_li = w_hit_acc ? bus.issue_id : w_si[L];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag_v <= 1'b0;
    end else if (w_adv[1] & r_vld[0]) begin
      r_tag_v    <= 1'b1;
      r_tag_a    <= r_a;
      r_tag_b    <= r_b;
      r_tag_prod <= w_prod;
    end
  end
`else
  assign w_hit = 1'b0;
  assign w_lv  = w_sv[L];
  assign w_lp  = w_sp[L];
  assign w_lm  = w_sm[L];
  assign w_li  = w_si[L];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      if (w_adv[0]) r_vld[0] <= w_acc & ~w_hit;
      for (int k = 1; k < L; k++) begin
        if (w_adv[k]) r_vld[k] <= w_sv[k];
      end
      if (w_adv[L]) r_vld[L] <= w_lv;
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv[0]) begin
      r_a       <= w_a_ext;
      r_b       <= w_b_ext;
      r_mulh[0] <= (bus.op != 2'b00);
      r_id[0]   <= bus.issue_id;
    end
    for (int k = 1; k < L; k++) begin
      if (w_adv[k]) begin
        r_prod[k] <= w_sp[k];
        r_mulh[k] <= w_sm[k];
        r_id[k]   <= w_si[k];
      end
    end
    if (w_adv[L]) begin
      r_prod[L] <= w_lp;
      r_mulh[L] <= w_lm;
      r_id[L]   <= w_li;
    end
  end

  assign bus.issue_ready = w_adv[0];
  assign bus.wb_done     = r_vld[L];
  assign bus.wb_id       = r_id[L];
  assign bus.wb_rd       = r_mulh[L] ? r_prod[L][PW-1:XLEN] : r_prod[L][XLEN-1:0];
endmodule

// File: tb/tb_mul_unit_pipelined.sv
// Randomised bench for mul_unit_pipelined against an in-order scoreboard model.
// Define MUL_PRODUCT_REUSE_EN when compiling to exercise the reuse path.
module tb_mul_unit_pipelined;
  localparam int XLEN   = 32;
  localparam int STAGES = 3;
  localparam int ID_W   = 3;
`ifdef MUL_PRODUCT_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_unit_pipelined_if #(.XLEN(XLEN), .ID_W(ID_W)) bus();

  mul_unit_pipelined #(.XLEN(XLEN), .STAGES(STAGES), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] rd;
    int              acc;
    int              rdy;
  } ent_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int ret_cnt = 0;
  int illegal_cnt = 0;

  ent_t            q[$];
  logic [XLEN-1:0] res_log[$];
  int              lat_log[$];
  logic [ID_W-1:0] id_log[$];
  logic            tag_v = 1'b0;
  logic [XLEN:0]   tag_a;
  logic [XLEN:0]   tag_b;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
    sb = (op[1] == 1'b0) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = 64'(sa * sb);
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [XLEN:0] ext(input logic [XLEN-1:0] x, input logic s);
    return {s & x[XLEN-1], x};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: in-order queue; an entry reaches writeback at
  // max(accept + latency, predecessor retire + 1).
  initial begin
    ent_t e;
    bit ed, er, hit, was_empty;
    logic [XLEN:0] ea, eb;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        tag_v = 1'b0;
      end else begin
        ed = (q.size() > 0) && (cyc >= q[0].rdy);
        er = (q.size() < STAGES) || (ed && bus.wb_ack);
        chk("issue_ready", bus.issue_ready, er);
        chk("wb_done", bus.wb_done, ed);
        if (ed) begin
          chk("wb_id", bus.wb_id, q[0].id);
          chk("wb_rd", bus.wb_rd, q[0].rd);
        end
        was_empty = (q.size() == 0);
        if (ed && bus.wb_ack) begin
          e = q.pop_front();
          res_log.push_back(e.rd);
          lat_log.push_back(cyc - e.acc);
          id_log.push_back(e.id);
          ret_cnt++;
          if (q.size() > 0 && q[0].rdy < cyc + 1) q[0].rdy = cyc + 1;
        end
        if (bus.issue_new_request) begin
          if (!er) begin
            illegal_cnt++;
          end else begin
            ea  = ext(bus.rs1, bus.op == 2'b01 || bus.op == 2'b10);
            eb  = ext(bus.rs2, !bus.op[1]);
            hit = REUSE && tag_v && was_empty && (ea == tag_a) && (eb == tag_b);
            if (!hit) begin
              tag_v = 1'b1;
              tag_a = ea;
              tag_b = eb;
            end
            e.id  = bus.issue_id;
            e.rd  = ref_mul(bus.op, bus.rs1, bus.rs2);
            e.acc = cyc;
            e.rdy = cyc + (hit ? 1 : STAGES);
            q.push_back(e);
            acc_cnt++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [ID_W-1:0] id);
    bus.op = op;
    bus.rs1 = a;
    bus.rs2 = b;
    bus.issue_id = id;
    bus.issue_new_request = 1'b1;
    tick();
    bus.issue_new_request = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic clear_logs();
    res_log.delete();
    lat_log.delete();
    id_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [XLEN-1:0] pool [4];
    logic [ID_W-1:0] nid;
    int a0, r0;
    pool[0] = 32'h12345678;
    pool[1] = 32'h9ABCDEF0;
    pool[2] = 32'h80000000;
    pool[3] = 32'hFFFFFFFF;
    bus.issue_new_request = 1'b0;
    bus.issue_id = '0;
    bus.op = 2'b00;
    bus.rs1 = '0;
    bus.rs2 = '0;
    bus.wb_ack = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    chk("model_mulhu", ref_mul(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    chk("model_mulh", ref_mul(2'b01, 32'h80000000, 32'h80000000), 32'h40000000);
    chk("model_mulhsu", ref_mul(2'b10, 32'hFFFFFFFF, 32'h00000002), 32'hFFFFFFFF);
    chk("model_mul", ref_mul(2'b00, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    chk("model_mul_big", ref_mul(2'b00, 32'h12345678, 32'h9ABCDEF0), 32'h242D2080);

    // Directed plan values, wb_ack held high
    bus.wb_ack = 1'b1;
    tick();
    clear_logs();
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0);
    issue(2'b01, 32'h80000000, 32'h80000000, 3'd1);
    issue(2'b10, 32'hFFFFFFFF, 32'h00000002, 3'd2);
    issue(2'b00, 32'd7, 32'hFFFFFFFD, 3'd3);
    drain(20);
    chk("plan_count", res_log.size(), 4);
    if (res_log.size() == 4) begin
      chk("plan_mulhu", res_log[0], 32'hFFFFFFFE);
      chk("plan_mulh", res_log[1], 32'h40000000);
      chk("plan_mulhsu", res_log[2], 32'hFFFFFFFF);
      chk("plan_mul", res_log[3], 32'hFFFFFFEB);
      chk("plan_latency", lat_log[0], STAGES);
    end

    // Six back-to-back requests, full throughput
    clear_logs();
    for (int i = 0; i < 6; i++) issue(2'($urandom_range(0, 3)), $urandom, $urandom, 3'(i));
    drain(20);
    chk("b2b_count", res_log.size(), 6);
    if (res_log.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("b2b_id", id_log[i], i);
        chk("b2b_latency", lat_log[i], STAGES);
      end
    end

    // Fill with writeback stalled
    clear_logs();
    a0 = acc_cnt;
    bus.wb_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.op = 2'($urandom_range(0, 3));
      bus.rs1 = $urandom;
      bus.rs2 = $urandom;
      bus.issue_id = 3'(i);
      bus.issue_new_request = 1'b1;
      tick();
    end
    bus.issue_new_request = 1'b0;
    chk("fill_accepted", acc_cnt - a0, STAGES);
    chk("fill_ready_low", bus.issue_ready, 1'b0);
    bus.wb_ack = 1'b1;
    drain(20);
    chk("fill_drained", res_log.size(), STAGES);

    // Reset with two requests in flight
    issue(2'b00, 32'd5, 32'd6, 3'd5);
    issue(2'b11, 32'd9, 32'd9, 3'd6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    r0 = ret_cnt;
    chk("post_reset_ready", bus.issue_ready, 1'b1);
    repeat (6) tick();
    chk("flush_none_retired", ret_cnt - r0, 0);
    chk("post_reset_done", bus.wb_done, 1'b0);

    // Product reuse: MULH then MUL with equal operands, then a busy-pipe repeat
    clear_logs();
    issue(2'b01, 32'h12345678, 32'h9ABCDEF0, 3'd1);
    drain(20);
    issue(2'b00, 32'h12345678, 32'h9ABCDEF0, 3'd2);
    issue(2'b00, 32'h12345678, 32'h9ABCDEF0, 3'd3);
    drain(20);
    chk("reuse_count", res_log.size(), 3);
    if (res_log.size() == 3) begin
      chk("reuse_rd", res_log[1], 32'h242D2080);
      chk("reuse_latency", lat_log[1], REUSE ? 1 : STAGES);
      chk("busy_rd", res_log[2], 32'h242D2080);
      chk("busy_latency", lat_log[2], STAGES);
    end

    // Random traffic with stalls, repeated operands and occasional reset
    nid = '0;
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      bus.issue_new_request = ($urandom_range(0, 2) != 0);
      bus.op = 2'($urandom_range(0, 3));
      bus.rs1 = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : $urandom;
      bus.rs2 = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : $urandom;
      bus.issue_id = nid;
      nid = nid + 1'b1;
      bus.wb_ack = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.issue_new_request = 1'b0;
    rst_n = 1'b1;
    bus.wb_ack = 1'b1;
    drain(50);

    $display("note: %0d issue attempts while not ready were ignored", illegal_cnt);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
